// File: rtl/timer_alarm_if.sv
// Register-write, acknowledge and status bundle between the timer_alarm block and its host.
// The host drives the write port and acknowledge; the block drives irq, status and fire count.
interface timer_alarm_if #(
    parameter int WIDTH = 32
);
    logic             wr_en;
    logic [1:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             irq_ack;
    logic             irq;
    logic [7:0]       alarm_status;
    logic [15:0]      fire_count;

    modport master (
        output wr_en, wr_addr, wr_data, irq_ack,
        input  irq, alarm_status, fire_count
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, irq_ack,
        output irq, alarm_status, fire_count
    );
endinterface

// File: rtl/timer_alarm.sv
// Compare/alarm stage on the free-running millisecond counter: one-shot or auto-reload
// target match raising a registered interrupt, with acknowledge, sticky overrun and fire count.
module timer_alarm #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] millisec_counter,
    timer_alarm_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       ctrl_q, ctrl_d;         // {irq_en, periodic, arm}
    logic [WIDTH-1:0] compare_q, compare_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic [15:0]      fire_count_q, fire_count_d;
    logic             irq_q, irq_d;
    logic [7:0]       status_q, status_d;

    logic match, ctrl_wr, cmp_wr, per_wr;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block infers a latch.
        state_d      = state_q;
        ctrl_d       = ctrl_q;
        compare_d    = compare_q;
        period_d     = period_q;
        target_d     = target_q;
        pending_d    = pending_q;
        overrun_d    = overrun_q;
        fire_count_d = fire_count_q;

        match   = (state_q == ARMED) && (millisec_counter == target_q);
        ctrl_wr = bus.wr_en && (bus.wr_addr == 2'd0);
        cmp_wr  = bus.wr_en && (bus.wr_addr == 2'd1);
        per_wr  = bus.wr_en && (bus.wr_addr == 2'd2);

        if (bus.irq_ack) begin
            pending_d = 1'b0;
            overrun_d = 1'b0;
            if (state_q == DONE) state_d = IDLE;
        end

        // A control write in the same cycle discards the match entirely.
        if (match && !ctrl_wr) begin
            fire_count_d = fire_count_q + 16'd1;
            pending_d    = 1'b1;
            if (pending_q && !bus.irq_ack) overrun_d = 1'b1;
            if (ctrl_q[1] && (period_q != '0)) target_d = target_q + period_q;
            else                               state_d  = DONE;
        end

        if (cmp_wr) begin
            compare_d = bus.wr_data;
            if (state_q == ARMED) target_d = bus.wr_data;
        end

        if (per_wr) period_d = bus.wr_data;

        if (ctrl_wr) begin
            ctrl_d = bus.wr_data[2:0];
            if (bus.wr_data[0]) begin
                target_d = compare_q;
                state_d  = ARMED;
            end else begin
                state_d  = IDLE;
            end
        end

        irq_d    = pending_q & ctrl_q[2];
        status_d = {4'b0000, state_q, overrun_q, pending_q};
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ctrl_q       <= '0;
            compare_q    <= '0;
            period_q     <= '0;
            target_q     <= '0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            fire_count_q <= '0;
            irq_q        <= 1'b0;
            status_q     <= '0;
        end else begin
            state_q      <= state_d;
            ctrl_q       <= ctrl_d;
            compare_q    <= compare_d;
            period_q     <= period_d;
            target_q     <= target_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            fire_count_q <= fire_count_d;
            irq_q        <= irq_d;
            status_q     <= status_d;
        end
    end

    assign bus.irq          = irq_q;
    assign bus.alarm_status = status_q;
    assign bus.fire_count   = fire_count_q;
endmodule

// File: tb/tb_timer_alarm.sv
// Directed bench for timer_alarm: a one-shot vector table followed by hand-written
// sequences for periodic wrap, overrun, ack/match collision, disarm-on-match and reset.
module tb_timer_alarm;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] cnt = '0;

    timer_alarm_if #(.WIDTH(32)) bus ();

    timer_alarm #(.WIDTH(32)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .millisec_counter (cnt),
        .bus              (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] data;
        logic        ack;
        logic [31:0] cnt;
        logic        e_irq;
        logic [7:0]  e_stat;
        logic [15:0] e_fire;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, sample just after it.
    task automatic step(input logic we, input logic [1:0] a, input logic [31:0] d,
                        input logic ack, input logic [31:0] c);
        bus.wr_en   = we;
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.irq_ack = ack;
        cnt         = c;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input logic [31:0] c);
        step(1'b0, 2'd0, 32'd0, 1'b0, c);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle(32'd0);
        reset_n = 1'b1;
    endtask

    function automatic void push(logic we, logic [1:0] addr, logic [31:0] data, logic ack,
                                 logic [31:0] c, logic e_irq, logic [7:0] e_stat,
                                 logic [15:0] e_fire);
        vec_t v;
        v.we = we; v.addr = addr; v.data = data; v.ack = ack; v.cnt = c;
        v.e_irq = e_irq; v.e_stat = e_stat; v.e_fire = e_fire;
        vecs.push_back(v);
    endfunction

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.irq_ack = 1'b0;

        // Reset held 3 cycles under random writes and counter activity.
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)), $urandom);
            check($sformatf("rst%0d irq", i), 32'(bus.irq), 32'd0);
            check($sformatf("rst%0d status", i), 32'(bus.alarm_status), 32'h00);
            check($sformatf("rst%0d fire", i), 32'(bus.fire_count), 32'd0);
        end
        reset_n = 1'b1;
        idle(32'd0);

        // One-shot: compare=10, control=0b101, counter ramps; ack, then counter passes 10 again.
        push(1, 2'd1, 32'd10, 0, 32'd0, 0, 8'h00, 16'd0);
        push(1, 2'd0, 32'd5,  0, 32'd1, 0, 8'h00, 16'd0);
        for (int c = 2; c <= 9; c++) push(0, 2'd0, 32'd0, 0, 32'(c), 0, 8'h04, 16'd0);
        push(0, 2'd0, 32'd0, 0, 32'd10, 0, 8'h04, 16'd1);
        push(0, 2'd0, 32'd0, 0, 32'd11, 1, 8'h09, 16'd1);
        push(0, 2'd0, 32'd0, 0, 32'd12, 1, 8'h09, 16'd1);
        push(0, 2'd0, 32'd0, 1, 32'd13, 1, 8'h09, 16'd1);
        push(0, 2'd0, 32'd0, 0, 32'd14, 0, 8'h00, 16'd1);
        push(0, 2'd0, 32'd0, 0, 32'd15, 0, 8'h00, 16'd1);
        push(0, 2'd0, 32'd0, 0, 32'd10, 0, 8'h00, 16'd1);
        foreach (vecs[i]) begin
            step(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].ack, vecs[i].cnt);
            check($sformatf("vec%0d irq", i), 32'(bus.irq), 32'(vecs[i].e_irq));
            check($sformatf("vec%0d status", i), 32'(bus.alarm_status), 32'(vecs[i].e_stat));
            check($sformatf("vec%0d fire", i), 32'(bus.fire_count), 32'(vecs[i].e_fire));
        end

        // Periodic wrap: matches at 0xFFFFFFFE, 0x2, 0x6.
        do_reset();
        step(1, 2'd1, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFC);
        step(1, 2'd2, 32'd4,         0, 32'hFFFF_FFFC);
        step(1, 2'd0, 32'd7,         0, 32'hFFFF_FFFC);
        begin
            int exp_fire = 0;
            for (int i = 0; i < 13; i++) begin
                logic [31:0] c;
                c = 32'hFFFF_FFFC + 32'(i);
                if (c == 32'hFFFF_FFFE || c == 32'd2 || c == 32'd6) exp_fire++;
                idle(c);
                check($sformatf("wrap cnt=%0h fire", c), 32'(bus.fire_count), 32'(exp_fire));
            end
        end
        check("wrap status", 32'(bus.alarm_status), 32'h07);
        check("wrap irq", 32'(bus.irq), 32'd1);

        // Overrun: period=2, no ack; then one ack clears bits 1:0.
        do_reset();
        step(1, 2'd1, 32'd5, 0, 32'd0);
        step(1, 2'd2, 32'd2, 0, 32'd0);
        step(1, 2'd0, 32'd7, 0, 32'd0);
        for (int c = 1; c <= 8; c++) idle(32'(c));
        check("ovr status set", 32'(bus.alarm_status), 32'h07);
        check("ovr fire", 32'(bus.fire_count), 32'd2);
        step(0, 2'd0, 32'd0, 1, 32'd8);
        check("ovr irq after ack edge", 32'(bus.irq), 32'd1);
        idle(32'd8);
        check("ovr status cleared", 32'(bus.alarm_status), 32'h04);
        check("ovr irq cleared", 32'(bus.irq), 32'd0);

        // Ack collides with a match (target 11 after the match at 9).
        idle(32'd9);
        idle(32'd10);
        check("coll fire before", 32'(bus.fire_count), 32'd3);
        step(0, 2'd0, 32'd0, 1, 32'd11);
        check("coll fire", 32'(bus.fire_count), 32'd4);
        idle(32'd12);
        check("coll status", 32'(bus.alarm_status), 32'h05);

        // Disarm written the cycle the counter equals the target.
        do_reset();
        step(1, 2'd1, 32'd3, 0, 32'd0);
        step(1, 2'd0, 32'd5, 0, 32'd0);
        idle(32'd1);
        idle(32'd2);
        step(1, 2'd0, 32'd0, 0, 32'd3);
        idle(32'd4);
        check("disarm status", 32'(bus.alarm_status), 32'h00);
        check("disarm fire", 32'(bus.fire_count), 32'd0);

        // Reset while ARMED with an interrupt pending.
        do_reset();
        step(1, 2'd1, 32'd2, 0, 32'd0);
        step(1, 2'd2, 32'd5, 0, 32'd0);
        step(1, 2'd0, 32'd7, 0, 32'd0);
        idle(32'd1);
        idle(32'd2);
        idle(32'd3);
        check("pre-rst irq", 32'(bus.irq), 32'd1);
        check("pre-rst status", 32'(bus.alarm_status), 32'h05);
        reset_n = 1'b0;
        idle(32'd4);
        check("mid-rst irq", 32'(bus.irq), 32'd0);
        check("mid-rst status", 32'(bus.alarm_status), 32'h00);
        check("mid-rst fire", 32'(bus.fire_count), 32'd0);
        reset_n = 1'b1;
        idle(32'd7);
        idle(32'd8);
        check("post-rst status", 32'(bus.alarm_status), 32'h00);
        check("post-rst fire", 32'(bus.fire_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/timer_alarm.md
# timer_alarm

Compare/alarm stage that sits directly downstream of the millisecond timer and consumes its free-running `millisec_counter`. It holds a software-programmed target value and raises a registered interrupt when the counter reaches that target. It supports one-shot and periodic (auto-reload) modes, and provides an acknowledge handshake, a sticky overrun flag and a fire counter.

## Interface
- `WIDTH`, default 32: width of the counter, compare and period registers.
- `clock` in 1: single system clock; every register updates on its rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `millisec_counter` in WIDTH: count value from the timer; advances by at most 1 per clock and may return to 0.
- `wr_en` in 1: register write strobe, one cycle per write.
- `wr_addr` in 2: write target. 0 = control, 1 = compare, 2 = period, 3 = ignored.
- `wr_data` in WIDTH: write data.
- `irq_ack` in 1: one-cycle pulse that clears `pending` and `overrun`.
- `irq` out 1: registered output equal to `pending & ctrl_irq_en`.
- `alarm_status` out 8: bit 0 = pending, bit 1 = overrun, bits 3:2 = state (0 IDLE, 1 ARMED, 2 DONE), bits 7:4 = 0.
- `fire_count` out 16: number of matches since reset; wraps modulo 2^16.

## Operation
- **Control register bits**
  - [0] `arm`
  - [1] `periodic`
  - [2] `irq_en`
  - Other bits read as don't-care.
- **Internal registers:** `compare_reg`, `period_reg`, `target` (all WIDTH bits), `pending`, `overrun`, `state`.
- **Match definition:** `match = (state == ARMED) && (millisec_counter == target)`. Only equality counts, so a counter that wraps or resets still reaches the target on a later pass.
- **IDLE**
  - Control write with arm=1: `target <= compare_reg` (or `wr_data` if compare is written the same cycle; not possible with a single port), then go to ARMED.
- **ARMED**
  - On match, `fire_count += 1` and `pending <= 1`.
  - If `periodic=1` and `period_reg != 0`: `target <= target + period_reg`, truncated to WIDTH (mod 2^WIDTH wrap), and stay in ARMED.
  - Otherwise go to DONE.
- **DONE**
  - `irq_ack` returns the block to IDLE.
  - Control write with arm=1 re-arms the block, as from IDLE.
- **Disarm:** a control write with arm=0 goes to IDLE from any state. `pending` is unaffected.
- **Compare write while ARMED:** `compare_reg` and `target` both take `wr_data`. The new target is active from the next cycle.
- **Period write:** updates `period_reg` only. It is used at the next reload.
- **Overrun:** a match while `pending` is already 1 sets `overrun` (sticky).
- **Acknowledge:** `irq_ack` clears `pending` and `overrun`.
- **Simultaneous ack and match:** the match wins. `pending` stays 1, `overrun` is cleared, and `fire_count` increments.
- **Simultaneous control write and match in ARMED:** the write wins and the match is discarded.
- **Reset values (while `reset_n` is low):**
  - `state` = IDLE
  - `compare_reg`, `period_reg`, `target` = 0
  - `pending`, `overrun` = 0
  - control = 0
  - `fire_count` = 0
  - `irq` = 0
  - `alarm_status` = 0x00
  - Reset mid-match aborts everything with no residual pending.

## Timing
- Register writes take effect at the clock edge where `wr_en` is sampled high.
- A control arm write at edge E puts the block in ARMED after E; the first possible match is sampled at E+1.
- A match sampled at edge M gives `pending = 1` and `fire_count` updated after M, and `irq` high after M+1 (one extra register stage).
- `irq_ack` sampled at edge A gives `pending = 0` after A and `irq = 0` after A+1.
- `alarm_status` is registered and reflects state and flags one cycle after the update edge.
- In periodic mode, back-to-back matches are possible every `period_reg` counter increments, with a minimum of 1.

## Test plan
- **Reset:** hold `reset_n=0` for 3 cycles with random writes and counter activity -> `irq=0`, `alarm_status=0x00`, `fire_count=0`.
- **One-shot:** compare=10, control=0b101, counter ramps 0..20 -> exactly one `irq` rise 2 cycles after counter==10, state DONE, `fire_count=1`; ack -> `irq` low, state IDLE.
- **Periodic wrap:** compare=0xFFFF_FFFE, period=4, control=0b111, counter ramps through 0xFFFF_FFFE..0x0000_0006 -> matches at 0xFFFF_FFFE and 0x0000_0002, plus 0x0000_0006, `fire_count=3`.
- **Overrun:** periodic, period=2, no ack -> second match sets `alarm_status[1]=1`; a single ack clears bits 1:0.
- **Ack collides with match** on the same edge -> `pending` stays 1, `overrun=0`, `fire_count` increments.
- **Disarm and reset mid-operation:** control=0 written the cycle the counter equals the target -> no `pending`, state IDLE. Separately, `reset_n` low while ARMED -> all outputs return to reset values on the next edge.
